// File: rtl/instr_enc_pkg.sv
// Shared encodings for the decode pipeline: opcodes, control-bundle layout and
// the stall FSM state type.
package instr_enc_pkg;

  localparam int unsigned OPC_W  = 6;
  localparam int unsigned CTRL_W = 12;

  localparam logic [OPC_W-1:0] OP_ADD      = 6'h00;
  localparam logic [OPC_W-1:0] OP_SUB      = 6'h01;
  localparam logic [OPC_W-1:0] OP_MUL      = 6'h02;
  localparam logic [OPC_W-1:0] OP_LDB      = 6'h10;
  localparam logic [OPC_W-1:0] OP_LDW      = 6'h11;
  localparam logic [OPC_W-1:0] OP_STB      = 6'h12;
  localparam logic [OPC_W-1:0] OP_STW      = 6'h13;
  localparam logic [OPC_W-1:0] OP_MOVRM1   = 6'h20;
  localparam logic [OPC_W-1:0] OP_TLBWRITE = 6'h21;
  localparam logic [OPC_W-1:0] OP_IRET     = 6'h22;
  localparam logic [OPC_W-1:0] OP_BEQ      = 6'h30;
  localparam logic [OPC_W-1:0] OP_JUMP     = 6'h31;

  // Bit positions inside the control bundle, MSB first.
  localparam int unsigned C_REGDST    = 11;
  localparam int unsigned C_BRANCH    = 10;
  localparam int unsigned C_MEMREAD   = 9;
  localparam int unsigned C_MEMTOREG  = 8;
  localparam int unsigned C_MEMWRITE  = 7;
  localparam int unsigned C_ALUSRC    = 6;
  localparam int unsigned C_REGWRITE  = 5;
  localparam int unsigned C_JUMP      = 4;
  localparam int unsigned C_WORD      = 3;
  localparam int unsigned C_TLBWRITE  = 2;
  localparam int unsigned C_IRET      = 1;
  localparam int unsigned C_IGNOREOP2 = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MUL_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/decode_ctrl_rom.sv
// Combinational opcode decoder: control bundle, illegal flag and which source
// specifiers the instruction actually reads.
module decode_ctrl_rom
  import instr_enc_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              illegal,
  output logic              uses_rs1,
  output logic              uses_rs2
);

  logic rs2_read;

  always_comb begin
    ctrl     = '0;
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    rs2_read = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL: begin
        ctrl[C_REGDST]   = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        rs2_read         = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        ctrl[C_MEMREAD]  = 1'b1;
        ctrl[C_MEMTOREG] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        ctrl[C_REGWRITE] = 1'b1;
        ctrl[C_WORD]     = (opcode == OP_LDW);
      end
      OP_STB, OP_STW: begin
        ctrl[C_MEMWRITE] = 1'b1;
        ctrl[C_ALUSRC]   = 1'b1;
        ctrl[C_WORD]     = (opcode == OP_STW);
        rs2_read         = 1'b1;
      end
      OP_MOVRM1: begin
        ctrl[C_REGDST]    = 1'b1;
        ctrl[C_REGWRITE]  = 1'b1;
        ctrl[C_IGNOREOP2] = 1'b1;
      end
      OP_TLBWRITE: begin
        ctrl[C_TLBWRITE] = 1'b1;
        uses_rs1         = 1'b0;
      end
      OP_IRET: begin
        ctrl[C_IRET] = 1'b1;
        uses_rs1     = 1'b0;
      end
      OP_BEQ: begin
        ctrl[C_BRANCH] = 1'b1;
        rs2_read       = 1'b1;
      end
      OP_JUMP: begin
        ctrl[C_JUMP] = 1'b1;
        uses_rs1     = 1'b0;
      end
      default: begin
        illegal  = 1'b1;
        uses_rs1 = 1'b0;
      end
    endcase
    uses_rs2 = rs2_read && !ctrl[C_IGNOREOP2];
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage between IF/ID and ID/EX with load-use and MUL
// structural stalls, flush, and illegal-opcode flagging.
module decode_ctrl_pipe
  import instr_enc_pkg::*;
#(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned LU_BUBBLES  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [REG_W-1:0]   out_rs1,
  output logic [REG_W-1:0]   out_rs2,
  output logic [REG_W-1:0]   out_dst,
  output logic               out_illegal,
  output logic               busy
);

  localparam int unsigned CNT_MAX = (MUL_LATENCY > LU_BUBBLES) ? MUL_LATENCY : LU_BUBBLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RS1_LSB = INSTR_W - OPC_W - REG_W;
  localparam int unsigned RS2_LSB = RS1_LSB - REG_W;
  localparam int unsigned RD_LSB  = RS2_LSB - REG_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] LU_CNT  = CNT_W'(LU_BUBBLES - 1);
  localparam bit               LU_MULTI = (LU_BUBBLES > 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lu_pending_q, lu_pending_d;
  logic [REG_W-1:0]    ld_dst_q, ld_dst_d;
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
  logic [REG_W-1:0]    out_rs1_q, out_rs1_d;
  logic [REG_W-1:0]    out_rs2_q, out_rs2_d;
  logic [REG_W-1:0]    out_dst_q, out_dst_d;
  logic                out_illegal_q, out_illegal_d;

  logic [OPC_W-1:0]  opcode;
  logic [REG_W-1:0]  rs1, rs2, rd, dec_dst;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal, dec_uses_rs1, dec_uses_rs2;
  logic              lu_hazard, out_hold, in_fire;

  assign opcode = in_instr[INSTR_W-1 -: OPC_W];
  assign rs1    = in_instr[RS1_LSB +: REG_W];
  assign rs2    = in_instr[RS2_LSB +: REG_W];
  assign rd     = in_instr[RD_LSB +: REG_W];

  if (RD_LSB > 0) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^in_instr[RD_LSB-1:0];
  end

  decode_ctrl_rom u_rom (
    .opcode   (opcode),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2)
  );

  assign dec_dst   = !dec_ctrl[C_REGWRITE] ? '0 : (dec_ctrl[C_REGDST] ? rd : rs2);
  assign lu_hazard = lu_pending_q && in_valid &&
                     ((dec_uses_rs1 && rs1 == ld_dst_q) || (dec_uses_rs2 && rs2 == ld_dst_q));
  assign out_hold  = out_valid_q && !out_ready;
  assign in_ready  = rst_n && !flush && (state_q == RUN) && !lu_hazard && !out_hold;
  assign in_fire   = in_valid && in_ready;

  // The cycle in which a load-use hazard is detected is already the first
  // bubble, so LU_STALL only covers the remaining LU_BUBBLES-1 cycles.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lu_pending_d  = lu_pending_q;
    ld_dst_d      = ld_dst_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_ctrl_d    = out_ctrl_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_dst_d     = out_dst_q;
    out_illegal_d = out_illegal_q;
    if (in_fire) begin
      out_valid_d   = 1'b1;
      out_ctrl_d    = dec_ctrl;
      out_rs1_d     = rs1;
      out_rs2_d     = rs2;
      out_dst_d     = dec_dst;
      out_illegal_d = dec_illegal;
      lu_pending_d  = dec_ctrl[C_MEMREAD] && (dec_dst != '0);
      ld_dst_d      = dec_dst;
      if (opcode == OP_MUL && MUL_LATENCY > 1) begin
        state_d = MUL_BUSY;
        cnt_d   = MUL_CNT;
      end
    end else if (!out_hold) begin
      case (state_q)
        RUN: begin
          if (lu_hazard) begin
            if (LU_MULTI) begin
              state_d = LU_STALL;
              cnt_d   = LU_CNT;
            end else begin
              lu_pending_d = 1'b0;
            end
          end
        end
        LU_STALL: begin
          if (cnt_q <= CNT_ONE) begin
            state_d      = RUN;
            cnt_d        = '0;
            lu_pending_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        MUL_BUSY: begin
          if (cnt_q > CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (lu_hazard && LU_MULTI) begin
            state_d = LU_STALL;
            cnt_d   = LU_CNT;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            if (lu_hazard) lu_pending_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
    if (flush) begin
      state_d      = RUN;
      cnt_d        = '0;
      lu_pending_d = 1'b0;
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      lu_pending_q  <= 1'b0;
      ld_dst_q      <= '0;
      out_valid_q   <= 1'b0;
      out_ctrl_q    <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_dst_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lu_pending_q  <= lu_pending_d;
      ld_dst_q      <= ld_dst_d;
      out_valid_q   <= out_valid_d;
      out_ctrl_q    <= out_ctrl_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_dst_q     <= out_dst_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_dst     = out_dst_q;
  assign out_illegal = out_illegal_q;
  assign busy        = (state_q != RUN);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: per-opcode decode table plus
// hand-written stall, flush, illegal and reset sequences.
module tb_decode_ctrl_pipe;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, out_illegal, busy;
  logic [11:0] out_ctrl;
  logic [4:0]  out_rs1, out_rs2, out_dst;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(
    .INSTR_W     (32),
    .REG_W       (5),
    .MUL_LATENCY (4),
    .LU_BUBBLES  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_dst     (out_dst),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctrl;
    logic [4:0]  dst;
    logic        ill;
    logic        bsy;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                     input logic [4:0] b, input logic [4:0] d);
    return {op, a, b, d, 11'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{mk(OP_ADD,      5'd1, 5'd2, 5'd3), 12'h820, 5'd3, 1'b0, 1'b0};
    vecs[1]  = '{mk(OP_SUB,      5'd4, 5'd5, 5'd6), 12'h820, 5'd6, 1'b0, 1'b0};
    vecs[2]  = '{mk(OP_MUL,      5'd1, 5'd2, 5'd9), 12'h820, 5'd9, 1'b0, 1'b1};
    vecs[3]  = '{mk(OP_LDB,      5'd2, 5'd7, 5'd0), 12'h360, 5'd7, 1'b0, 1'b0};
    vecs[4]  = '{mk(OP_LDW,      5'd2, 5'd8, 5'd0), 12'h368, 5'd8, 1'b0, 1'b0};
    vecs[5]  = '{mk(OP_STB,      5'd3, 5'd4, 5'd5), 12'h0C0, 5'd0, 1'b0, 1'b0};
    vecs[6]  = '{mk(OP_STW,      5'd3, 5'd4, 5'd5), 12'h0C8, 5'd0, 1'b0, 1'b0};
    vecs[7]  = '{mk(OP_MOVRM1,   5'd1, 5'd2, 5'd7), 12'h821, 5'd7, 1'b0, 1'b0};
    vecs[8]  = '{mk(OP_TLBWRITE, 5'd1, 5'd2, 5'd3), 12'h004, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{mk(OP_IRET,     5'd1, 5'd2, 5'd3), 12'h002, 5'd0, 1'b0, 1'b0};
    vecs[10] = '{mk(OP_BEQ,      5'd1, 5'd2, 5'd3), 12'h400, 5'd0, 1'b0, 1'b0};
    vecs[11] = '{mk(OP_JUMP,     5'd1, 5'd2, 5'd3), 12'h010, 5'd0, 1'b0, 1'b0};
    vecs[12] = '{mk(6'h3F,       5'd1, 5'd2, 5'd3), 12'h000, 5'd0, 1'b1, 1'b0};
    vecs[13] = '{mk(6'h05,       5'd6, 5'd7, 5'd8), 12'h000, 5'd0, 1'b1, 1'b0};
    vecs[14] = '{mk(OP_LDB,      5'd1, 5'd0, 5'd0), 12'h360, 5'd0, 1'b0, 1'b0};

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_ctrl", 32'(out_ctrl), 32'd0);
    chk("rst out_rs1", 32'(out_rs1), 32'd0);
    chk("rst out_rs2", 32'(out_rs2), 32'd0);
    chk("rst out_dst", 32'(out_dst), 32'd0);
    chk("rst out_illegal", 32'(out_illegal), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    #9 rst_n = 1'b1;
    #1 chk("in_ready after reset", 32'(in_ready), 32'd1);
    tick();

    // Decode table, one isolated instruction per entry
    for (int i = 0; i < 15; i++) begin
      in_instr = vecs[i].instr;
      in_valid = 1'b1;
      #1 chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("vec%0d out_dst", i), 32'(out_dst), 32'(vecs[i].dst));
      chk($sformatf("vec%0d out_illegal", i), 32'(out_illegal), 32'(vecs[i].ill));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("vec%0d out_rs1", i), 32'(out_rs1), 32'(vecs[i].instr[25:21]));
      chk($sformatf("vec%0d out_rs2", i), 32'(out_rs2), 32'(vecs[i].instr[20:16]));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk($sformatf("vec%0d flushed valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d flushed busy", i), 32'(busy), 32'd0);
    end

    // Back-to-back ADD, SUB
    in_instr = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b1;
    tick();
    chk("b2b add valid", 32'(out_valid), 32'd1);
    chk("b2b add ctrl", 32'(out_ctrl), 32'h820);
    chk("b2b add dst", 32'(out_dst), 32'd3);
    in_instr = mk(OP_SUB, 5'd1, 5'd2, 5'd4);
    #1 chk("b2b sub ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b sub valid", 32'(out_valid), 32'd1);
    chk("b2b sub ctrl", 32'(out_ctrl), 32'h820);
    chk("b2b sub dst", 32'(out_dst), 32'd4);
    tick();
    chk("b2b drained", 32'(out_valid), 32'd0);

    // MUL structural stall: three idle output cycles before the ADD
    in_instr = mk(OP_MUL, 5'd1, 5'd2, 5'd9);
    in_valid = 1'b1;
    tick();
    chk("mul valid", 32'(out_valid), 32'd1);
    chk("mul dst", 32'(out_dst), 32'd9);
    chk("mul busy", 32'(busy), 32'd1);
    in_instr = mk(OP_ADD, 5'd3, 5'd4, 5'd10);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("mul stall%0d ready", k), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("mul stall%0d valid", k), 32'(out_valid), 32'd0);
    end
    #1 chk("mul exit ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("mul next valid", 32'(out_valid), 32'd1);
    chk("mul next dst", 32'(out_dst), 32'd10);
    chk("mul next busy", 32'(busy), 32'd0);
    tick();

    // Load-use on rs1: one bubble
    in_instr = mk(OP_LDW, 5'd1, 5'd5, 5'd0);
    in_valid = 1'b1;
    tick();
    chk("ldw ctrl", 32'(out_ctrl), 32'h368);
    chk("ldw dst", 32'(out_dst), 32'd5);
    in_instr = mk(OP_ADD, 5'd5, 5'd1, 5'd6);
    #1 chk("lu hazard ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu bubble valid", 32'(out_valid), 32'd0);
    #1 chk("lu resume ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu consumer valid", 32'(out_valid), 32'd1);
    chk("lu consumer dst", 32'(out_dst), 32'd6);
    // Independent consumer: no bubble
    in_instr = mk(OP_LDW, 5'd1, 5'd5, 5'd0);
    tick();
    in_instr = mk(OP_ADD, 5'd1, 5'd2, 5'd7);
    #1 chk("lu indep ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu indep valid", 32'(out_valid), 32'd1);
    chk("lu indep dst", 32'(out_dst), 32'd7);
    // JUMP reads no registers even if its fields match
    in_instr = mk(OP_LDW, 5'd1, 5'd5, 5'd0);
    tick();
    in_instr = mk(OP_JUMP, 5'd5, 5'd5, 5'd0);
    #1 chk("lu jump ready", 32'(in_ready), 32'd1);
    tick();
    chk("lu jump ctrl", 32'(out_ctrl), 32'h010);
    // Store reading the load target through rs2
    in_instr = mk(OP_LDW, 5'd1, 5'd5, 5'd0);
    tick();
    in_instr = mk(OP_STW, 5'd2, 5'd5, 5'd0);
    #1 chk("lu rs2 ready", 32'(in_ready), 32'd0);
    tick();
    chk("lu rs2 bubble", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("lu rs2 consumer ctrl", 32'(out_ctrl), 32'h0C8);
    tick();

    // Flush under backpressure with a simultaneous in_valid
    in_instr = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    in_instr = mk(OP_SUB, 5'd1, 5'd2, 5'd4);
    #1 chk("bp ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp hold valid", 32'(out_valid), 32'd1);
    chk("bp hold dst", 32'(out_dst), 32'd3);
    flush = 1'b1;
    #1 chk("flush ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush valid", 32'(out_valid), 32'd0);
    chk("flush busy", 32'(busy), 32'd0);
    tick();
    chk("flush not accepted", 32'(out_valid), 32'd0);
    // Flush during MUL_BUSY
    in_instr = mk(OP_MUL, 5'd1, 5'd2, 5'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush mul busy pre", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush mul busy post", 32'(busy), 32'd0);
    in_instr = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b1;
    #1 chk("flush mul ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("flush mul next valid", 32'(out_valid), 32'd1);
    tick();

    // Illegal opcode followed by BEQ
    in_instr = mk(6'h3F, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b1;
    tick();
    chk("ill flag", 32'(out_illegal), 32'd1);
    chk("ill ctrl", 32'(out_ctrl), 32'd0);
    chk("ill dst", 32'(out_dst), 32'd0);
    in_instr = mk(OP_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("beq flag", 32'(out_illegal), 32'd0);
    chk("beq ctrl", 32'(out_ctrl), 32'h400);
    chk("beq dst", 32'(out_dst), 32'd0);
    tick();

    // Async reset while MUL_BUSY has cnt = 2
    in_instr = mk(OP_MUL, 5'd1, 5'd2, 5'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rmul busy pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmul out_valid", 32'(out_valid), 32'd0);
    chk("rmul busy", 32'(busy), 32'd0);
    chk("rmul ctrl", 32'(out_ctrl), 32'd0);
    chk("rmul dst", 32'(out_dst), 32'd0);
    chk("rmul rs1", 32'(out_rs1), 32'd0);
    chk("rmul illegal", 32'(out_illegal), 32'd0);
    chk("rmul in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rmul ready after", 32'(in_ready), 32'd1);
    in_instr = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rmul add valid", 32'(out_valid), 32'd1);
    chk("rmul add dst", 32'(out_dst), 32'd3);
    chk("rmul add busy", 32'(busy), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
